// File: rtl/axil_mstr_replayer.sv
// axil_mstr_replayer
//   Re-drives logged shell-to-CL AXI-Lite transactions onto the CL-facing
//   master port. It also sinks the B and R responses, limits the number of
//   outstanding writes and reads, and reports status to the replay controller.
//
// Ports
//   clk, rstn                        clock, asynchronous active-low reset
//   pkt_valid/pkt_ready/pkt_*        replay packet input (pkt_mask: AW,W,AR)
//   aw*, w*, ar*                     request channels driven to the CL
//   b*, r*                           response channels from the CL (always ready)
//   wr_done_cnt, rd_done_cnt         wrapping B / R handshake counts
//   resp_err, proto_err              sticky error flags
//   idle                             no held packet and nothing outstanding
//
// state    | meaning
// ST_EMPTY | hold register free, pkt_ready asserted
// ST_HOLD  | packet held, re-driving its pending channels

module axil_mstr_replayer #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    pkt_valid,
   output logic                    pkt_ready,
   input  logic [2:0]              pkt_mask,
   input  logic [ADDR_WIDTH-1:0]   pkt_awaddr,
   input  logic [DATA_WIDTH-1:0]   pkt_wdata,
   input  logic [DATA_WIDTH/8-1:0] pkt_wstrb,
   input  logic [ADDR_WIDTH-1:0]   pkt_araddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    bvalid,
   output logic                    bready,
   input  logic [1:0]              bresp,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   output logic [31:0]             wr_done_cnt,
   output logic [31:0]             rd_done_cnt,
   output logic                    resp_err,
   output logic                    proto_err,
   output logic                    idle
);

   localparam int         STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [3:0] MAX_OUT    = 4'(MAX_OUTSTANDING);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              pend_q, pend_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic                    pkt_ready_q, pkt_ready_d;
   logic                    bready_q, rready_q;
   logic [3:0]              wr_out_q, wr_out_d;
   logic [3:0]              rd_out_q, rd_out_d;
   logic [31:0]             wr_done_q, wr_done_d;
   logic [31:0]             rd_done_q, rd_done_d;
   logic                    resp_err_q, resp_err_d;
   logic                    proto_err_q, proto_err_d;
   logic                    idle_q, idle_d;

   logic pkt_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs;

   // Read data is sunk without inspection.
   logic unused_rdata;
   assign unused_rdata = ^rdata;

   assign pkt_hs = pkt_valid & pkt_ready_q;
   assign aw_hs  = awvalid_q & awready;
   assign w_hs   = wvalid_q  & wready;
   assign ar_hs  = arvalid_q & arready;
   assign b_hs   = bvalid & bready_q;
   assign r_hs   = rvalid & rready_q;

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q & ~{aw_hs, w_hs, ar_hs};
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      araddr_d = araddr_q;

      case (state_q)
         ST_EMPTY: begin
            if (pkt_hs) begin
               awaddr_d = pkt_awaddr;
               wdata_d  = pkt_wdata;
               wstrb_d  = pkt_wstrb;
               araddr_d = pkt_araddr;
               pend_d   = pkt_mask;
               // An empty mask is consumed and dropped without leaving EMPTY.
               if (pkt_mask != 3'b000) state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Leaving one cycle after the last pend bit clears yields the bubble.
            if (pend_q == 3'b000) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      wr_out_d    = wr_out_q;
      rd_out_d    = rd_out_q;
      proto_err_d = proto_err_q;

      if (aw_hs && !b_hs) begin
         wr_out_d = wr_out_q + 4'd1;
      end else if (!aw_hs && b_hs) begin
         if (wr_out_q == 4'd0) proto_err_d = 1'b1;
         else                  wr_out_d    = wr_out_q - 4'd1;
      end

      if (ar_hs && !r_hs) begin
         rd_out_d = rd_out_q + 4'd1;
      end else if (!ar_hs && r_hs) begin
         if (rd_out_q == 4'd0) proto_err_d = 1'b1;
         else                  rd_out_d    = rd_out_q - 4'd1;
      end
   end

   always_comb begin
      // A raised valid holds until its handshake; the outstanding limit is
      // only consulted while the valid is low.
      if (awvalid_q && !awready) awvalid_d = 1'b1;
      else                       awvalid_d = pend_d[2] && (wr_out_d < MAX_OUT);

      wvalid_d = pend_d[1];

      if (arvalid_q && !arready) arvalid_d = 1'b1;
      else                       arvalid_d = pend_d[0] && (rd_out_d < MAX_OUT);

      pkt_ready_d = (state_d == ST_EMPTY);
      wr_done_d   = b_hs ? wr_done_q + 32'd1 : wr_done_q;
      rd_done_d   = r_hs ? rd_done_q + 32'd1 : rd_done_q;
      resp_err_d  = resp_err_q | (b_hs && (bresp != 2'b00)) | (r_hs && (rresp != 2'b00));
      idle_d      = (state_d == ST_EMPTY) && (wr_out_d == 4'd0) && (rd_out_d == 4'd0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_EMPTY;
         pend_q      <= 3'b000;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         araddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         pkt_ready_q <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         wr_out_q    <= 4'd0;
         rd_out_q    <= 4'd0;
         wr_done_q   <= 32'd0;
         rd_done_q   <= 32'd0;
         resp_err_q  <= 1'b0;
         proto_err_q <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         araddr_q    <= araddr_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         pkt_ready_q <= pkt_ready_d;
         bready_q    <= 1'b1;
         rready_q    <= 1'b1;
         wr_out_q    <= wr_out_d;
         rd_out_q    <= rd_out_d;
         wr_done_q   <= wr_done_d;
         rd_done_q   <= rd_done_d;
         resp_err_q  <= resp_err_d;
         proto_err_q <= proto_err_d;
         idle_q      <= idle_d;
      end
   end

   assign pkt_ready   = pkt_ready_q;
   assign awvalid     = awvalid_q;
   assign awaddr      = awaddr_q;
   assign wvalid      = wvalid_q;
   assign wdata       = wdata_q;
   assign wstrb       = wstrb_q;
   assign arvalid     = arvalid_q;
   assign araddr      = araddr_q;
   assign bready      = bready_q;
   assign rready      = rready_q;
   assign wr_done_cnt = wr_done_q;
   assign rd_done_cnt = rd_done_q;
   assign resp_err    = resp_err_q;
   assign proto_err   = proto_err_q;
   assign idle        = idle_q;

endmodule

// File: tb/tb_axil_mstr_replayer.sv
// Directed bench for axil_mstr_replayer: write replay, read backpressure,
// outstanding limit, channel ordering freedom, empty packet, orphan B and
// asynchronous reset mid-transaction.

module tb_axil_mstr_replayer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pkt_valid, pkt_ready;
   logic [2:0]  pkt_mask;
   logic [31:0] pkt_awaddr, pkt_wdata, pkt_araddr;
   logic [3:0]  pkt_wstrb;
   logic        awvalid, awready, wvalid, wready, arvalid, arready;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        bvalid, bready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [31:0] wr_done_cnt, rd_done_cnt;
   logic        resp_err, proto_err, idle;

   int n_chk  = 0;
   int n_pass = 0;

   // handshake monitor
   int          cyc = 0;
   int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0;
   int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
   int          max_wr = 0;
   logic [31:0] mon_awaddr = '0, mon_wdata = '0, mon_araddr = '0;
   logic [3:0]  mon_wstrb = '0;

   int s_aw, s_w, s_ar;
   bit stable;

   always #5 clk = ~clk;

   axil_mstr_replayer #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
   ) u_dut (
      .clk(clk), .rstn(rstn),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_mask(pkt_mask),
      .pkt_awaddr(pkt_awaddr), .pkt_wdata(pkt_wdata), .pkt_wstrb(pkt_wstrb),
      .pkt_araddr(pkt_araddr),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt),
      .resp_err(resp_err), .proto_err(proto_err), .idle(idle)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (awvalid && awready) begin
         n_aw <= n_aw + 1; aw_cyc <= cyc; mon_awaddr <= awaddr;
      end
      if (wvalid && wready) begin
         n_w <= n_w + 1; w_cyc <= cyc; mon_wdata <= wdata; mon_wstrb <= wstrb;
      end
      if (arvalid && arready) begin
         n_ar <= n_ar + 1; ar_cyc <= cyc; mon_araddr <= araddr;
      end
      if (bvalid && bready) n_b <= n_b + 1;
      if ((n_aw - n_b) > max_wr) max_wr <= n_aw - n_b;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pkt(input logic [2:0] m, input logic [31:0] aa, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] ra);
      bit got;
      got        = 1'b0;
      pkt_mask   = m;
      pkt_awaddr = aa;
      pkt_wdata  = wd;
      pkt_wstrb  = ws;
      pkt_araddr = ra;
      pkt_valid  = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         if (pkt_ready) got = 1'b1;
         else tick(1);
      end
      check("pkt_accept", 32'(got), 32'd1);
      tick(1);
      pkt_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      pkt_valid = 0; pkt_mask = 0; pkt_awaddr = 0; pkt_wdata = 0; pkt_wstrb = 0; pkt_araddr = 0;
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 32'hA5A5_0000;

      tick(3);
      check("rst_pkt_ready", 32'(pkt_ready), 32'd0);
      check("rst_bready",    32'(bready),    32'd0);
      check("rst_awvalid",   32'(awvalid),   32'd0);
      check("rst_idle",      32'(idle),      32'd1);
      check("rst_wr_done",   wr_done_cnt,    32'd0);
      rstn = 1'b1;
      tick(1);
      check("out_pkt_ready", 32'(pkt_ready), 32'd1);
      check("out_rready",    32'(rready),    32'd1);

      // write replay
      awready = 1; wready = 1;
      s_aw = n_aw; s_w = n_w;
      send_pkt(3'b110, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0);
      tick(1);
      check("wr_aw_count", 32'(n_aw - s_aw), 32'd1);
      check("wr_w_count",  32'(n_w - s_w),   32'd1);
      check("wr_awaddr",   mon_awaddr,       32'h100);
      check("wr_wdata",    mon_wdata,        32'hDEAD_BEEF);
      check("wr_wstrb",    32'(mon_wstrb),   32'hF);
      check("wr_busy",     32'(idle),        32'd0);
      bvalid = 1; bresp = 2'b00;
      tick(1);
      bvalid = 0;
      check("wr_done",     wr_done_cnt,      32'd1);
      check("wr_idle",     32'(idle),        32'd1);
      check("wr_resp_err", 32'(resp_err),    32'd0);
      check("wr_pkt_ready", 32'(pkt_ready),  32'd1);

      // read with backpressure
      awready = 0; wready = 0; arready = 0;
      s_ar = n_ar;
      send_pkt(3'b001, 32'h0, 32'h0, 4'h0, 32'h40);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!(arvalid && araddr == 32'h40)) stable = 1'b0;
         tick(1);
      end
      check("rd_ar_stable", 32'(stable),      32'd1);
      check("rd_ar_held",   32'(n_ar - s_ar), 32'd0);
      arready = 1;
      tick(1);
      arready = 0;
      check("rd_ar_count",  32'(n_ar - s_ar), 32'd1);
      check("rd_araddr",    mon_araddr,       32'h40);
      check("rd_ar_drop",   32'(arvalid),     32'd0);
      rvalid = 1; rresp = 2'b10;
      tick(1);
      rvalid = 0; rresp = 2'b00;
      check("rd_done",      rd_done_cnt,      32'd1);
      check("rd_resp_err",  32'(resp_err),    32'd1);
      tick(3);
      check("rd_err_sticky", 32'(resp_err),   32'd1);

      // outstanding limit
      awready = 1; wready = 1;
      s_aw = n_aw; s_w = n_w;
      for (int i = 0; i < 5; i++)
         send_pkt(3'b110, 32'h1000 + 32'(i * 4), 32'h5000 + 32'(i), 4'hF, 32'h0);
      tick(10);
      check("lim_aw_4",      32'(n_aw - s_aw), 32'd4);
      check("lim_w_5",       32'(n_w - s_w),   32'd5);
      check("lim_aw_low",    32'(awvalid),     32'd0);
      check("lim_pkt_held",  32'(pkt_ready),   32'd0);
      bvalid = 1;
      tick(1);
      bvalid = 0;
      check("lim_aw_rise",   32'(awvalid),     32'd1);
      tick(1);
      check("lim_aw_5",      32'(n_aw - s_aw), 32'd5);
      check("lim_awaddr_5",  mon_awaddr,       32'h1010);
      send_pkt(3'b110, 32'h1014, 32'h5005, 4'hF, 32'h0);
      tick(5);
      check("lim_aw6_gated", 32'(awvalid),     32'd0);
      check("lim_aw_still5", 32'(n_aw - s_aw), 32'd5);
      bvalid = 1;
      tick(5);
      bvalid = 0;
      tick(3);
      check("lim_aw_6",      32'(n_aw - s_aw), 32'd6);
      check("lim_wr_done",   wr_done_cnt,      32'd7);
      check("lim_max_out",   32'(max_wr),      32'd4);
      check("lim_no_proto",  32'(proto_err),   32'd0);
      check("lim_idle",      32'(idle),        32'd1);

      // ordering freedom
      awready = 0; arready = 0; wready = 1;
      s_aw = n_aw; s_w = n_w; s_ar = n_ar;
      send_pkt(3'b111, 32'h200, 32'h1234_5678, 4'h3, 32'h300);
      tick(3);
      check("ord_w_first",   32'(n_w - s_w),   32'd1);
      check("ord_aw_wait",   32'(n_aw - s_aw), 32'd0);
      check("ord_ar_wait",   32'(n_ar - s_ar), 32'd0);
      check("ord_w_drop",    32'(wvalid),      32'd0);
      check("ord_aw_high",   32'(awvalid),     32'd1);
      awready = 1; arready = 1;
      tick(1);
      awready = 0; arready = 0;
      check("ord_aw_done",   32'(n_aw - s_aw), 32'd1);
      check("ord_ar_done",   32'(n_ar - s_ar), 32'd1);
      check("ord_same_cyc",  32'(aw_cyc - ar_cyc), 32'd0);
      check("ord_w_before",  32'(w_cyc < aw_cyc), 32'd1);
      check("ord_awaddr",    mon_awaddr,       32'h200);
      check("ord_araddr",    mon_araddr,       32'h300);
      check("ord_bubble",    32'(pkt_ready),   32'd0);
      tick(1);
      check("ord_ready",     32'(pkt_ready),   32'd1);
      bvalid = 1; rvalid = 1;
      tick(1);
      bvalid = 0; rvalid = 0;
      check("ord_wr_done",   wr_done_cnt,      32'd8);
      check("ord_rd_done",   rd_done_cnt,      32'd2);
      check("ord_idle",      32'(idle),        32'd1);

      // empty mask
      s_aw = n_aw; s_w = n_w; s_ar = n_ar;
      awready = 1; wready = 1; arready = 1;
      send_pkt(3'b000, 32'h900, 32'h900, 4'hF, 32'h900);
      check("m0_ready",      32'(pkt_ready),   32'd1);
      tick(3);
      check("m0_no_bus",     32'((n_aw - s_aw) + (n_w - s_w) + (n_ar - s_ar)), 32'd0);
      check("m0_idle",       32'(idle),        32'd1);
      awready = 0; wready = 0; arready = 0;

      // B with nothing outstanding
      bvalid = 1;
      tick(1);
      bvalid = 0;
      check("orph_proto",    32'(proto_err),   32'd1);
      check("orph_wr_done",  wr_done_cnt,      32'd9);
      check("orph_idle",     32'(idle),        32'd1);

      // asynchronous reset while awvalid is high
      send_pkt(3'b100, 32'h500, 32'h0, 4'h0, 32'h0);
      check("rst_mid_aw",    32'(awvalid),     32'd1);
      #2 rstn = 1'b0;
      #1;
      check("arst_awvalid",  32'(awvalid),     32'd0);
      check("arst_wr_done",  wr_done_cnt,      32'd0);
      check("arst_rd_done",  rd_done_cnt,      32'd0);
      check("arst_idle",     32'(idle),        32'd1);
      check("arst_proto",    32'(proto_err),   32'd0);
      check("arst_resp",     32'(resp_err),    32'd0);
      tick(2);
      rstn = 1'b1;
      tick(2);
      check("arst_ready",    32'(pkt_ready),   32'd1);
      check("arst_aw_quiet", 32'(awvalid),     32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axil_mstr_replayer.md
Name: axil_mstr_replayer

Overview:
- Replay-side counterpart of the AXI-Lite master recorder. Consumes logged shell-to-CL AXI-Lite transactions (AW, W, AR) from the replay buffer and re-drives them onto the CL-facing AXI-Lite master port.
- Sinks the CL's B/R responses, bounds outstanding transactions, and reports completion counts, response errors and an idle indication to the replay controller.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width; strobe width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum issued-but-unresponded writes (AW) and, separately, reads (AR); range 1..15.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  replay packet valid.
- pkt_ready  out  1  replay packet accepted when pkt_valid & pkt_ready.
- pkt_mask  in  3  channels present in packet: bit2 AW, bit1 W, bit0 AR.
- pkt_awaddr  in  ADDR_WIDTH  logged awaddr.
- pkt_wdata  in  DATA_WIDTH  logged wdata.
- pkt_wstrb  in  DATA_WIDTH/8  logged wstrb.
- pkt_araddr  in  ADDR_WIDTH  logged araddr.
- awvalid/awready/awaddr  out/in/out  1/1/ADDR_WIDTH  AW channel to CL.
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  W channel to CL.
- arvalid/arready/araddr  out/in/out  1/1/ADDR_WIDTH  AR channel to CL.
- bvalid/bready/bresp  in/out/in  1/1/2  B channel from CL.
- rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  R channel from CL.
- wr_done_cnt  out  32  completed B handshakes, wrapping.
- rd_done_cnt  out  32  completed R handshakes, wrapping.
- resp_err  out  1  sticky: a B or R response carried resp != 2'b00.
- proto_err  out  1  sticky: a B/R response arrived with zero outstanding.
- idle  out  1  no held packet and no outstanding transactions.

Behaviour:
- Reset (rstn=0, asynchronous):
  - all valids, pkt_ready, bready and rready = 0;
  - counters, hold register, pending mask and outstanding counts = 0;
  - resp_err and proto_err = 0; idle = 1.
  - Reset mid-transaction drops everything in flight. No completion is reported.
- Hold register, two states:
  - EMPTY: pkt_ready=1. On pkt handshake latch all packet fields; pend <= pkt_mask.
    - pkt_mask != 0 -> go to HOLD.
    - pkt_mask == 0 -> packet is consumed and discarded, stay EMPTY, no bus activity.
  - HOLD: pkt_ready=0. Exit to EMPTY in the cycle after the last pending bit clears. This gives one bubble cycle between packets.
- Channel drive in HOLD (all outputs registered; data comes from the hold register and is stable while valid):
  - awvalid = pend[2] & (wr_out < MAX_OUTSTANDING);
  - wvalid = pend[1];
  - arvalid = pend[0] & (rd_out < MAX_OUTSTANDING).
  - Each pend bit clears on its own handshake; the matching valid drops the following cycle.
  - AW, W and AR are independent: any order is allowed, simultaneous handshakes are allowed.
  - Once asserted, a valid stays high until its handshake. The outstanding gate is evaluated only while the valid is low.
- Outstanding counters, 4 bits each:
  - wr_out +1 on AW handshake, -1 on B handshake; both in one cycle -> unchanged.
  - rd_out behaves the same with AR and R.
  - A B handshake with wr_out==0 (or R with rd_out==0): set proto_err, counter stays 0, done count still increments.
- Response sink:
  - bready = rready = 1 whenever out of reset.
  - B handshake -> wr_done_cnt+1; R handshake -> rd_done_cnt+1. Both count modulo 2^32 (0xFFFFFFFF -> 0).
  - resp_err set on any handshake with bresp!=0 or rresp!=0; it clears only on reset.
  - rdata is ignored.
- idle = (state==EMPTY) & (wr_out==0) & (rd_out==0), registered.

Test Plan:
- Write replay: packet mask=3'b110, awaddr=0x100, wdata=0xDEADBEEF, wstrb=0xF; CL ready immediately, bresp=0 one cycle later.
  - Required: one AW and one W handshake with those values; wr_done_cnt=1; idle returns to 1; resp_err=0.
- Read with backpressure: mask=3'b001, araddr=0x40; arready held low 5 cycles.
  - Required: arvalid and araddr=0x40 stable for all 5 cycles; single AR handshake; rresp=2'b10 -> rd_done_cnt=1, resp_err=1 and stays 1.
- Outstanding limit: 6 write packets with MAX_OUTSTANDING=4, B withheld.
  - Required: exactly 4 AW handshakes, then awvalid stays low.
  - Releasing one B allows the 5th AW; no more than 4 are ever outstanding.
- Ordering freedom: mask=3'b111, wready=1, awready=0, arready=0 for 3 cycles, then all 1.
  - Required: W completes first; AW and AR complete together later; one bubble cycle, then pkt_ready=1.
- Edge cases:
  - mask=0 packet -> accepted, no bus activity.
  - B with no outstanding write -> proto_err=1.
  - rstn pulsed low while awvalid=1 -> awvalid=0 asynchronously, counters=0, idle=1.
